// File: rtl/ppi_phase_commutator.sv
// Polyphase interpolator output commutator: one packed frame in, L serial samples out, double-buffered.
// Optional build macro PPI_COMMUTATOR_ZERO_ON_IDLE_EN forces o_data to zero while idle.
module ppi_phase_commutator #(
    parameter int gp_data_width           = 8,
    parameter int gp_interpolation_factor = 4
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst,
    input  logic                                              i_ena,
    input  logic [gp_interpolation_factor*gp_data_width-1:0]  i_data,
    input  logic                                              i_valid,
    output logic                                              o_ready,
    output logic [gp_data_width-1:0]                          o_data,
    output logic                                              o_valid,
    output logic [$clog2(gp_interpolation_factor)-1:0]        o_phase
);

    localparam int W  = gp_data_width;
    localparam int L  = gp_interpolation_factor;
    localparam int PW = $clog2(L);
    localparam logic [PW-1:0] LAST = PW'(L - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_n;
    logic [L*W-1:0]  active, active_n;
    logic [L*W-1:0]  shadow, shadow_n;
    logic            shadow_full, shadow_full_n;
    logic [PW-1:0]   phase_n;
    logic [W-1:0]    data_n;
    logic            valid_n;
    logic            accept;
    logic [W-1:0]    act_lane [L];

    for (genvar p = 0; p < L; p++) begin : g_lane
        assign act_lane[p] = active[p*W +: W];
    end

    assign o_ready = ~shadow_full;
    assign accept  = i_ena & i_valid & ~shadow_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            active      <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            o_phase     <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
        end else begin
            state       <= state_n;
            active      <= active_n;
            shadow      <= shadow_n;
            shadow_full <= shadow_full_n;
            o_phase     <= phase_n;
            o_data      <= data_n;
            o_valid     <= valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        active_n      = active;
        shadow_n      = shadow;
        shadow_full_n = shadow_full;
        phase_n       = o_phase;
        data_n        = o_data;
        valid_n       = o_valid;
        if (i_ena) begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        active_n = i_data;
                        state_n  = SHIFT;
                        phase_n  = '0;
                        data_n   = i_data[W-1:0];
                        valid_n  = 1'b1;
                    end
                end
                SHIFT: begin
                    if (o_phase != LAST) begin
                        phase_n = o_phase + 1'b1;
                        data_n  = act_lane[phase_n];
                        if (accept) begin
                            shadow_n      = i_data;
                            shadow_full_n = 1'b1;
                        end
                    end else if (shadow_full) begin
                        active_n      = shadow;
                        shadow_full_n = 1'b0;
                        phase_n       = '0;
                        data_n        = shadow[W-1:0];
                    end else if (accept) begin
                        // Frame arriving exactly at wrap bypasses the shadow.
                        active_n = i_data;
                        phase_n  = '0;
                        data_n   = i_data[W-1:0];
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        phase_n = '0;
`ifdef PPI_COMMUTATOR_ZERO_ON_IDLE_EN
                        data_n  = '0;
`else
                        data_n  = o_data;
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppi_phase_commutator.sv
// Randomized + directed bench for ppi_phase_commutator against a sample-queue reference model.
module tb_ppi_phase_commutator;

    localparam int W = 8;
    localparam int L = 4;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_ena = 1'b0;
    logic [L*W-1:0]   i_data = '0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [W-1:0]     o_data;
    logic             o_valid;
    logic [1:0]       o_phase;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: pending samples in emission order; output pops one per enabled edge.
    logic [W-1:0] pend_d [$];
    int           pend_p [$];
    logic [W-1:0] m_data;
    logic         m_valid;
    int           m_phase;

    ppi_phase_commutator #(
        .gp_data_width          (W),
        .gp_interpolation_factor(L)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_ena  (i_ena),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_valid(o_valid),
        .o_phase(o_phase)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_d.delete();
        pend_p.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_phase = 0;
    endtask

    function automatic logic model_ready();
        return pend_d.size() < L;
    endfunction

    task automatic model_edge(input logic ena, input logic vld, input logic [L*W-1:0] d);
        if (ena) begin
            if (vld && model_ready()) begin
                for (int p = 0; p < L; p++) begin
                    pend_d.push_back(d[p*W +: W]);
                    pend_p.push_back(p);
                end
            end
            if (pend_d.size() > 0) begin
                m_data  = pend_d.pop_front();
                m_phase = pend_p.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_phase = 0;
`ifdef PPI_COMMUTATOR_ZERO_ON_IDLE_EN
                m_data  = '0;
`endif
            end
        end
    endtask

    task automatic check_outputs();
        check("o_valid", 32'(o_valid), 32'(m_valid));
        check("o_phase", 32'(o_phase), 32'(m_phase));
        check("o_data",  32'(o_data),  32'(m_data));
    endtask

    task automatic cycle(input logic ena, input logic vld, input logic [L*W-1:0] d);
        i_ena   = ena;
        i_valid = vld;
        i_data  = d;
        check("o_ready", 32'(o_ready), 32'(model_ready()));
        @(posedge i_clk);
        model_edge(ena, vld, d);
        #1;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, '0);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_phase", 32'(o_phase), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Single frame, then idle data behaviour.
        cycle(1'b1, 1'b1, 32'h44332211);
        check("first_sample", 32'(o_data), 32'h11);
        idle_cycles(3);
        check("last_sample", 32'(o_data), 32'h44);
        idle_cycles(2);
`ifdef PPI_COMMUTATOR_ZERO_ON_IDLE_EN
        check("idle_data", 32'(o_data), 32'h00);
`else
        check("idle_data", 32'(o_data), 32'h44);
`endif

        // Back-to-back with overrun attempt: B at phase 1, C while shadow full.
        cycle(1'b1, 1'b1, 32'h44332211);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h88776655);
        check("shadow_ready", 32'(o_ready), 32'd0);
        cycle(1'b1, 1'b1, 32'hDDCCBBAA);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (o_valid) check("no_overrun", 32'(o_data >= 8'hAA), 32'd0);
        end
        idle_cycles(2);

        // Enable stall after sample 0x22.
        cycle(1'b1, 1'b1, 32'h44332211);
        cycle(1'b1, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 32'h12345678);
            check("stall_data", 32'(o_data), 32'h22);
        end
        idle_cycles(4);

        // Async reset during phase 2.
        cycle(1'b1, 1'b1, 32'h44332211);
        idle_cycles(2);
        #2 i_rst = 1'b1;
        #1;
        model_reset();
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_data",  32'(o_data),  32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        idle_cycles(5);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
                  $urandom());
        end
        idle_cycles(L + 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
